// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: op encodings, access sizes,
// FSM states and small op-decoding helpers.
package mem_access_pkg;

    localparam int WBSEL_WIDTH = 2;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LB       = 4'd1,
        LH       = 4'd2,
        LW       = 4'd3,
        LD       = 4'd4,
        LBU      = 4'd5,
        LHU      = 4'd6,
        LWU      = 4'd7,
        SB       = 4'd8,
        SH       = 4'd9,
        SW       = 4'd10,
        SD       = 4'd11
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_t;

    function automatic logic mem_is_load(input mem_op_t op);
        return (op >= LB) && (op <= LWU);
    endfunction

    function automatic logic mem_is_store(input mem_op_t op);
        return (op >= SB) && (op <= SD);
    endfunction

    function automatic logic [1:0] mem_size(input mem_op_t op);
        logic [1:0] size;
        case (op)
            LH, LHU, SH: size = SIZE_H;
            LW, LWU, SW: size = SIZE_W;
            LD, SD:      size = SIZE_D;
            default:     size = SIZE_B;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus request/response bundle; the pipeline stage is the master and
// holds the request until the slave answers with dresp_valid.
interface mem_access_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  dreq_valid;
    logic                  dreq_we;
    logic [ADDR_W-1:0]     dreq_addr;
    logic [1:0]            dreq_size;
    logic [DATA_W/8-1:0]   dreq_strobe;
    logic [DATA_W-1:0]     dreq_wdata;
    logic                  dresp_valid;
    logic [DATA_W-1:0]     dresp_data;

    modport master (
        output dreq_valid, dreq_we, dreq_addr, dreq_size, dreq_strobe, dreq_wdata,
        input  dresp_valid, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_we, dreq_addr, dreq_size, dreq_strobe, dreq_wdata,
        output dresp_valid, dresp_data
    );
endinterface

// File: rtl/mem_access_align.sv
// Combinational byte-lane logic: alignment check, store strobe/data lane
// shifting and load extraction with sign/zero extension.
module mem_align
    import mem_access_pkg::*;
(
    input  mem_op_t     op,
    input  logic [2:0]  offset,
    input  logic [63:0] store_data,
    input  logic [63:0] load_data,
    output logic        misalign,
    output logic [1:0]  size,
    output logic [7:0]  strobe,
    output logic [63:0] wdata,
    output logic [63:0] load_value
);
    logic [3:0]  nbytes;
    logic [63:0] shifted;

    assign size   = mem_size(op);
    assign nbytes = 4'd1 << size;
    assign wdata  = store_data << {offset, 3'b000};
    assign shifted = load_data >> {offset, 3'b000};

    always_comb begin
        misalign = 1'b0;
        case (size)
            SIZE_H:  misalign = offset[0];
            SIZE_W:  misalign = |offset[1:0];
            SIZE_D:  misalign = |offset;
            default: misalign = 1'b0;
        endcase
    end

    // A lane is enabled when it falls inside [offset, offset + nbytes).
    for (genvar gi = 0; gi < 8; gi++) begin : g_strobe
        assign strobe[gi] = (4'(gi) >= {1'b0, offset}) &&
                            (4'(gi) < ({1'b0, offset} + nbytes));
    end

    always_comb begin
        load_value = shifted;
        case (op)
            LB:      load_value = {{56{shifted[7]}},  shifted[7:0]};
            LH:      load_value = {{48{shifted[15]}}, shifted[15:0]};
            LW:      load_value = {{32{shifted[31]}}, shifted[31:0]};
            LBU:     load_value = {56'd0, shifted[7:0]};
            LHU:     load_value = {48'd0, shifted[15:0]};
            LWU:     load_value = {32'd0, shifted[31:0]};
            default: load_value = shifted;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues held bus requests for loads/stores,
// stalls the pipeline while outstanding and passes other instructions through.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic                   flush,
    input  mem_op_t                mem_op_i,
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic [DATA_W-1:0]      store_data_i,
    input  logic [WBSEL_WIDTH-1:0] WBsel_i,
    input  logic                   RFwe_i,
    input  logic [4:0]             rdaddr_i,
    input  logic [31:0]            inst_i,
    input  logic [ADDR_W-1:0]      inst_addr_i,
    mem_access_if.master           bus,
    output logic                   stallreq_mem,
    output logic                   misalign_o,
    output logic [WBSEL_WIDTH-1:0] WBsel_o,
    output logic                   RFwe_o,
    output logic [4:0]             rdaddr_o,
    output logic [DATA_W-1:0]      rd_wdata_o,
    output logic [31:0]            inst_o,
    output logic [ADDR_W-1:0]      inst_addr_o
);
    state_t                   state_reg;
    logic                     dreq_valid_reg;
    logic                     dreq_we_reg;
    logic [ADDR_W-1:0]        dreq_addr_reg;
    logic [1:0]               dreq_size_reg;
    logic [7:0]               dreq_strobe_reg;
    logic [DATA_W-1:0]        dreq_wdata_reg;
    logic [DATA_W-1:0]        data_reg;
    mem_op_t                  op_reg;
    logic [2:0]               off_reg;
    logic [WBSEL_WIDTH-1:0]   wbsel_reg;
    logic                     rfwe_reg;
    logic [4:0]               rdaddr_reg;
    logic [31:0]              inst_reg;
    logic [ADDR_W-1:0]        inst_addr_reg;

    mem_op_t                  align_op;
    logic [2:0]               align_off;
    logic                     align_misalign;
    logic [1:0]               align_size;
    logic [7:0]               align_strobe;
    logic [63:0]              align_wdata;
    logic [63:0]              align_load;
    logic                     is_mem;
    logic                     start;
    logic                     in_idle;
    logic                     rfwe_raw;
    logic                     unused_stall;

    assign unused_stall = ^{stall[5], stall[3:0]};

    // Only one access is in flight, so the aligner serves the incoming op in
    // IDLE and the latched op (for load extraction) everywhere else.
    assign in_idle   = (state_reg == IDLE);
    assign align_op  = in_idle ? mem_op_i : op_reg;
    assign align_off = in_idle ? addr_i[2:0] : off_reg;

    mem_align u_align (
        .op         (align_op),
        .offset     (align_off),
        .store_data (store_data_i),
        .load_data  (bus.dresp_data),
        .misalign   (align_misalign),
        .size       (align_size),
        .strobe     (align_strobe),
        .wdata      (align_wdata),
        .load_value (align_load)
    );

    assign is_mem = mem_is_load(mem_op_i) || mem_is_store(mem_op_i);
    assign start  = in_idle && is_mem && !align_misalign && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            dreq_valid_reg  <= 1'b0;
            dreq_we_reg     <= 1'b0;
            dreq_addr_reg   <= '0;
            dreq_size_reg   <= '0;
            dreq_strobe_reg <= '0;
            dreq_wdata_reg  <= '0;
            data_reg        <= '0;
            op_reg          <= MEM_NONE;
            off_reg         <= '0;
            wbsel_reg       <= '0;
            rfwe_reg        <= 1'b0;
            rdaddr_reg      <= '0;
            inst_reg        <= '0;
            inst_addr_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg       <= WAIT;
                        dreq_valid_reg  <= 1'b1;
                        dreq_we_reg     <= mem_is_store(mem_op_i);
                        dreq_addr_reg   <= {addr_i[ADDR_W-1:3], 3'b000};
                        dreq_size_reg   <= align_size;
                        dreq_strobe_reg <= align_strobe;
                        dreq_wdata_reg  <= align_wdata;
                        op_reg          <= mem_op_i;
                        off_reg         <= addr_i[2:0];
                        wbsel_reg       <= WBsel_i;
                        rfwe_reg        <= RFwe_i;
                        rdaddr_reg      <= rdaddr_i;
                        inst_reg        <= inst_i;
                        inst_addr_reg   <= inst_addr_i;
                    end
                end
                WAIT: begin
                    if (bus.dresp_valid) begin
                        dreq_valid_reg <= 1'b0;
                        state_reg      <= flush ? IDLE : DONE;
                        if (!flush && mem_is_load(op_reg))
                            data_reg <= align_load;
                    end else if (flush) begin
                        state_reg <= ABORT;
                    end
                end
                ABORT: begin
                    if (bus.dresp_valid) begin
                        dreq_valid_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                DONE: begin
                    if (!stall[4] || flush)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.dreq_valid  = dreq_valid_reg;
    assign bus.dreq_we     = dreq_we_reg;
    assign bus.dreq_addr   = dreq_addr_reg;
    assign bus.dreq_size   = dreq_size_reg;
    assign bus.dreq_strobe = dreq_strobe_reg;
    assign bus.dreq_wdata  = dreq_wdata_reg;

    assign stallreq_mem = start || (state_reg == WAIT) || (state_reg == ABORT);
    assign misalign_o   = in_idle && is_mem && align_misalign && !rst;

    always_comb begin
        WBsel_o     = WBsel_i;
        rfwe_raw    = RFwe_i;
        rdaddr_o    = rdaddr_i;
        rd_wdata_o  = DATA_W'(addr_i);
        inst_o      = inst_i;
        inst_addr_o = inst_addr_i;
        if (!in_idle) begin
            WBsel_o     = wbsel_reg;
            rfwe_raw    = rfwe_reg;
            rdaddr_o    = rdaddr_reg;
            rd_wdata_o  = data_reg;
            inst_o      = inst_reg;
            inst_addr_o = inst_addr_reg;
        end
    end

    // Bubbles emitted while stalled, aborted, trapped or in reset never write.
    assign RFwe_o = rfwe_raw && !rst && !stallreq_mem &&
                    (state_reg != ABORT) && !misalign_o;
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads/stores with varied bus
// latency, misalignment, flush/abort, external stall hold and mid-access reset.
module tb_mem_access;
    import mem_access_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [5:0]             stall;
    logic                   flush;
    mem_op_t                mem_op_i;
    logic [63:0]            addr_i;
    logic [63:0]            store_data_i;
    logic [WBSEL_WIDTH-1:0] WBsel_i;
    logic                   RFwe_i;
    logic [4:0]             rdaddr_i;
    logic [31:0]            inst_i;
    logic [63:0]            inst_addr_i;
    logic                   stallreq_mem;
    logic                   misalign_o;
    logic [WBSEL_WIDTH-1:0] WBsel_o;
    logic                   RFwe_o;
    logic [4:0]             rdaddr_o;
    logic [63:0]            rd_wdata_o;
    logic [31:0]            inst_o;
    logic [63:0]            inst_addr_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access_if bus ();

    mem_access #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .mem_op_i     (mem_op_i),
        .addr_i       (addr_i),
        .store_data_i (store_data_i),
        .WBsel_i      (WBsel_i),
        .RFwe_i       (RFwe_i),
        .rdaddr_i     (rdaddr_i),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .bus          (bus),
        .stallreq_mem (stallreq_mem),
        .misalign_o   (misalign_o),
        .WBsel_o      (WBsel_o),
        .RFwe_o       (RFwe_o),
        .rdaddr_o     (rdaddr_o),
        .rd_wdata_o   (rd_wdata_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full access: issue in IDLE, lat WAIT cycles (response in the last),
    // then DONE, optionally held by stall[4] for hold cycles.
    task automatic access(input mem_op_t op, input logic [63:0] addr, input logic [63:0] sd,
                          input logic [63:0] rdata, input int lat, input int hold,
                          input logic [1:0] exp_size, input logic [7:0] exp_strobe,
                          input logic [63:0] exp_wdata, input logic [63:0] exp_rd,
                          input logic is_store);
        mem_op_i     = op;
        addr_i       = addr;
        store_data_i = sd;
        RFwe_i       = !is_store;
        rdaddr_i     = 5'd9;
        #1;
        check("issue_stallreq", 64'(stallreq_mem), 64'd1);
        check("issue_rfwe", 64'(RFwe_o), 64'd0);
        check("issue_valid", 64'(bus.dreq_valid), 64'd0);
        tick();
        for (int i = 0; i < lat; i++) begin
            bus.dresp_valid = (i == lat - 1);
            bus.dresp_data  = (i == lat - 1) ? rdata : 64'hA5A5_A5A5_A5A5_A5A5;
            #1;
            check("wait_valid", 64'(bus.dreq_valid), 64'd1);
            check("wait_we", 64'(bus.dreq_we), 64'(is_store));
            check("wait_addr", bus.dreq_addr, {addr[63:3], 3'b000});
            check("wait_size", 64'(bus.dreq_size), 64'(exp_size));
            check("wait_strobe", 64'(bus.dreq_strobe), 64'(exp_strobe));
            if (is_store) check("wait_wdata", bus.dreq_wdata, exp_wdata);
            check("wait_stallreq", 64'(stallreq_mem), 64'd1);
            check("wait_rfwe", 64'(RFwe_o), 64'd0);
            tick();
        end
        bus.dresp_valid = 1'b0;
        bus.dresp_data  = 64'h0;
        mem_op_i        = MEM_NONE;
        addr_i          = 64'hDEAD;
        stall           = (hold > 0) ? 6'b010000 : 6'b000000;
        #1;
        check("done_stallreq", 64'(stallreq_mem), 64'd0);
        check("done_valid", 64'(bus.dreq_valid), 64'd0);
        check("done_rfwe", 64'(RFwe_o), 64'(!is_store));
        check("done_rdaddr", 64'(rdaddr_o), 64'd9);
        if (!is_store) check("done_rd", rd_wdata_o, exp_rd);
        for (int h = 1; h < hold; h++) begin
            tick();
            check("hold_rd", rd_wdata_o, exp_rd);
            check("hold_valid", 64'(bus.dreq_valid), 64'd0);
        end
        stall = 6'b000000;
        tick();
        $display("access op=%0d addr=%h strobe=%h rd=%h", op, addr, exp_strobe, rd_wdata_o);
    endtask

    initial begin
        rst = 1'b1;
        stall = '0;
        flush = 1'b0;
        mem_op_i = LD;
        addr_i = 64'h40;
        store_data_i = '0;
        WBsel_i = 2'd1;
        RFwe_i = 1'b1;
        rdaddr_i = 5'd3;
        inst_i = 32'h0000_0013;
        inst_addr_i = 64'h8000_0000;
        bus.dresp_valid = 1'b0;
        bus.dresp_data = '0;
        tick();
        tick();
        check("rst_valid", 64'(bus.dreq_valid), 64'd0);
        check("rst_rfwe", 64'(RFwe_o), 64'd0);
        check("rst_misalign", 64'(misalign_o), 64'd0);
        rst = 1'b0;
        mem_op_i = MEM_NONE;
        tick();
        check("rst_valid_after", 64'(bus.dreq_valid), 64'd0);
        $display("reset done");

        // Non-memory instruction passes through combinationally.
        addr_i = 64'h1234;
        rdaddr_i = 5'd5;
        inst_i = 32'h00b5_0533;
        #1;
        check("add_rd", rd_wdata_o, 64'h1234);
        check("add_rfwe", 64'(RFwe_o), 64'd1);
        check("add_stallreq", 64'(stallreq_mem), 64'd0);
        check("add_rdaddr", 64'(rdaddr_o), 64'd5);
        check("add_inst", 64'(inst_o), 64'h00b5_0533);
        tick();
        check("add_valid", 64'(bus.dreq_valid), 64'd0);
        $display("pass-through rd=%h", rd_wdata_o);

        access(LB,  64'h1003, 64'h0, 64'h0000_0000_80FF_0000, 1, 0, SIZE_B, 8'h08,
               64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        access(LBU, 64'h1003, 64'h0, 64'h0000_0000_80FF_0000, 1, 0, SIZE_B, 8'h08,
               64'h0, 64'h0000_0000_0000_0080, 1'b0);
        access(SH,  64'h2006, 64'hBEEF, 64'h0, 3, 0, SIZE_H, 8'hC0,
               64'hBEEF_0000_0000_0000, 64'h0, 1'b1);
        access(LH,  64'h000A, 64'h0, 64'h0000_0000_8001_0000, 2, 0, SIZE_H, 8'h0C,
               64'h0, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
        access(SD,  64'h0010, 64'h0123_4567_89AB_CDEF, 64'h0, 1, 0, SIZE_D, 8'hFF,
               64'h0123_4567_89AB_CDEF, 64'h0, 1'b1);

        // Misaligned word: no request, no stall, no write.
        mem_op_i = LW;
        addr_i = 64'h3002;
        RFwe_i = 1'b1;
        #1;
        check("mis_flag", 64'(misalign_o), 64'd1);
        check("mis_rfwe", 64'(RFwe_o), 64'd0);
        check("mis_stallreq", 64'(stallreq_mem), 64'd0);
        tick();
        check("mis_valid", 64'(bus.dreq_valid), 64'd0);
        mem_op_i = MEM_NONE;
        #1;
        check("mis_clear", 64'(misalign_o), 64'd0);
        $display("misaligned LW addr=3002");

        // Flush in WAIT with a 4-cycle response: request held, data dropped.
        mem_op_i = LD;
        addr_i = 64'h100;
        tick();
        mem_op_i = MEM_NONE;
        flush = 1'b1;
        #1;
        check("flush_valid", 64'(bus.dreq_valid), 64'd1);
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.dresp_valid = (i == 2);
            bus.dresp_data = 64'hDEAD_BEEF_DEAD_BEEF;
            #1;
            check("abort_valid", 64'(bus.dreq_valid), 64'd1);
            check("abort_addr", bus.dreq_addr, 64'h100);
            check("abort_stallreq", 64'(stallreq_mem), 64'd1);
            check("abort_rfwe", 64'(RFwe_o), 64'd0);
            tick();
        end
        bus.dresp_valid = 1'b0;
        addr_i = 64'h55;
        #1;
        check("abort_idle_stallreq", 64'(stallreq_mem), 64'd0);
        check("abort_idle_valid", 64'(bus.dreq_valid), 64'd0);
        check("abort_idle_rd", rd_wdata_o, 64'h55);
        check("abort_idle_rfwe", 64'(RFwe_o), 64'd1);
        $display("flush/abort done rd=%h", rd_wdata_o);

        access(LD, 64'h108, 64'h0, 64'h1122_3344_5566_7788, 2, 0, SIZE_D, 8'hFF,
               64'h0, 64'h1122_3344_5566_7788, 1'b0);
        access(LW, 64'h4004, 64'h0, 64'h8000_0000_1234_5678, 1, 5, SIZE_W, 8'hF0,
               64'h0, 64'hFFFF_FFFF_8000_0000, 1'b0);
        access(LWU, 64'h4004, 64'h0, 64'h8000_0000_1234_5678, 1, 0, SIZE_W, 8'hF0,
               64'h0, 64'h0000_0000_8000_0000, 1'b0);

        // Flush arriving together with the response goes straight to IDLE.
        mem_op_i = LW;
        addr_i = 64'h300;
        tick();
        mem_op_i = MEM_NONE;
        flush = 1'b1;
        bus.dresp_valid = 1'b1;
        bus.dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        flush = 1'b0;
        bus.dresp_valid = 1'b0;
        addr_i = 64'h77;
        #1;
        check("flushresp_stallreq", 64'(stallreq_mem), 64'd0);
        check("flushresp_valid", 64'(bus.dreq_valid), 64'd0);
        check("flushresp_rd", rd_wdata_o, 64'h77);
        $display("flush with response rd=%h", rd_wdata_o);

        // Reset in WAIT.
        mem_op_i = LD;
        addr_i = 64'h200;
        tick();
        check("rstwait_valid_before", 64'(bus.dreq_valid), 64'd1);
        rst = 1'b1;
        mem_op_i = MEM_NONE;
        tick();
        check("rstwait_valid", 64'(bus.dreq_valid), 64'd0);
        check("rstwait_stallreq", 64'(stallreq_mem), 64'd0);
        rst = 1'b0;
        tick();
        check("rstwait_valid_after", 64'(bus.dreq_valid), 64'd0);
        $display("reset in WAIT done");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access pipeline stage between the ex_mem register and the mem_wb register. It issues loads and stores to the data bus through a request-held handshake and raises a stall request while an access is outstanding. Load data is extracted and sign/zero-extended into the writeback value; non-memory instructions pass straight through to mem_wb combinationally.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data bus width; fixed at one doubleword

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  6  controller stall vector; stage advances when ~stall[4]
- flush  in  1  pipeline flush
- mem_op_i  in  4  mem_op_t from ex_mem
- addr_i  in  64  effective address (ALU result)
- store_data_i  in  64  rs2 value
- WBsel_i, RFwe_i, rdaddr_i  in  WBSEL_WIDTH/1/5  writeback controls
- inst_i, inst_addr_i  in  32/64  instruction and its PC
- dreq_valid  out  1  bus request valid, registered
- dreq_we  out  1  1 = store
- dreq_addr  out  64  doubleword-aligned address
- dreq_size  out  2  0=B, 1=H, 2=W, 3=D
- dreq_strobe  out  8  byte enables
- dreq_wdata  out  64  lane-shifted store data
- dresp_valid  in  1  access complete; load data valid
- dresp_data  in  64  aligned doubleword
- stallreq_mem  out  1  stall request to controller
- misalign_o  out  1  misaligned access detected
- WBsel_o, RFwe_o, rdaddr_o, rd_wdata_o, inst_o, inst_addr_o  out  to mem_wb

## Operation
- States: IDLE, WAIT, DONE, ABORT.
- IDLE, mem_op_i == MEM_NONE: pass-through. rd_wdata_o = addr_i; the other outputs equal their inputs.
- IDLE, memory op, aligned, !flush: latch all request fields into registers and go to WAIT.
- IDLE, misaligned (H: addr[0]; W: addr[1:0]; D: addr[2:0] nonzero): no request is issued. misalign_o=1, RFwe_o=0, no stall.
- WAIT: dreq_* are held stable until dresp_valid. On dresp_valid, capture the extracted load value (stores capture nothing) and go to DONE.
- DONE: outputs come from the captured value. Go to IDLE when ~stall[4] or flush.
- flush in WAIT: go to ABORT. The request stays held until dresp_valid, the response is discarded, then go to IDLE.
- Load extract: shift dresp_data right by addr[2:0]*8, then sign-extend for LB/LH/LW or zero-extend for LBU/LHU/LWU/LD.
- Store: strobe = size mask << addr[2:0]; wdata = store_data << addr[2:0]*8.
- stallreq_mem = (IDLE & aligned memory op & !flush) | WAIT | ABORT.
- While stallreq_mem or ABORT is active, RFwe_o=0 so no bubble can write the register file.
- Reset values: state=IDLE, dreq_valid=0, dreq_* fields=0, captured data=0, misalign_o=0. RFwe_o follows the pass-through path with inputs gated: RFwe_o=0 during rst.

## Timing
- Request issue: dreq_valid rises one cycle after the op appears in IDLE.
- Load latency: issue cycle + bus latency + 1 cycle in DONE. The minimum with 1-cycle bus response is 3 cycles of occupancy.
- dresp_valid is ignored in IDLE and DONE.
- dresp_valid in the same cycle as flush in WAIT: the response is discarded and the state goes to IDLE.
- rst mid-access goes to IDLE immediately; the bus is reset by the same rst.
- DONE held by an external stall keeps its data indefinitely and never re-issues.
- stall[4] and flush together in DONE: flush wins and the state goes to IDLE.

## Structure
- The shared param package holds:
  - mem_op_t enum (4 bits): MEM_NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD
  - size encodings
  - WBSEL_WIDTH
- Sub-module mem_align (combinational) contains: the misalign check, strobe/wdata generation, and load extract/extend.
- mem_access holds the FSM and the request/capture registers.

## Test plan
- ADD passes through: addr_i=0x1234, RFwe_i=1 -> same-cycle rd_wdata_o=0x1234, stallreq_mem=0, dreq_valid stays 0.
- LB at 0x...1003, dresp_data=0x0000_0000_80FF_0000 -> strobe=0x08, rd_wdata_o=0xFFFF_FFFF_FFFF_FF80. The same access as LBU -> 0x80.
- SH at 0x...06, store_data=0xBEEF, 3-cycle bus -> strobe=0xC0, wdata=0xBEEF_0000_0000_0000. dreq fields stay stable all 3 cycles; stallreq_mem drops on entering DONE.
- LW at 0x...02 -> misalign_o=1, no dreq_valid, RFwe_o=0.
- flush during WAIT with 4-cycle response -> request held until dresp_valid, data discarded, IDLE afterwards. A following LD issues normally.
- DONE with stall[4] held 5 cycles -> rd_wdata_o constant, no second dreq_valid. rst asserted in WAIT -> dreq_valid=0 and IDLE next cycle.
